imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. It accepts one RV32 instruction word per cycle over a valid/ready handshake and decodes the immediate for all five immediate formats (I, S, B, U, J). It sign-extends the result to XLEN bits and returns it through a registered output stage backed by a one-entry skid buffer. It sits between fetch/instruction-register and the register-read/execute stage and replaces the purely combinational I/S/B extender.

---
 rtl/imm_gen_pipe.sv | 135 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32 immediate generator: decodes I/S/B/U/J immediates and sign-extends
// them to XLEN. The output register is backed by a one-entry skid buffer, so in_ready is a flop.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int TAG_W       = 8,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [31:0]      out_instr,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_I   = 3'd0;
  localparam logic [2:0] FMT_S   = 3'd1;
  localparam logic [2:0] FMT_B   = 3'd2;
  localparam logic [2:0] FMT_U   = 3'd3;
  localparam logic [2:0] FMT_J   = 3'd4;
  localparam logic [2:0] FMT_BAD = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [31:0]      instr;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic        s;
  logic [2:0]  dec_fmt;
  logic        dec_illegal;
  logic        dec_zero;
  logic [31:0] imm32;
  entry_t      dec;
  entry_t      out_q;
  entry_t      skid_q;
  logic        out_v;
  logic        skid_v;
  logic        accept;
  logic        drain;

  assign s = in_instr[31];

  // Format resolution; R-type resolves to I with a zero immediate, unknown opcodes to 111.
  always_comb begin
    dec_fmt  = in_imm_src;
    dec_zero = 1'b0;
    if (AUTO_DECODE) begin
      case (in_instr[6:0])
        7'b0000011, 7'b0010011,
        7'b1100111, 7'b1110011: dec_fmt = FMT_I;
        7'b0100011:             dec_fmt = FMT_S;
        7'b1100011:             dec_fmt = FMT_B;
        7'b0110111, 7'b0010111: dec_fmt = FMT_U;
        7'b1101111:             dec_fmt = FMT_J;
        7'b0110011: begin
          dec_fmt  = FMT_I;
          dec_zero = 1'b1;
        end
        default:                dec_fmt = FMT_BAD;
      endcase
    end
    dec_illegal = (dec_fmt > FMT_J);
  end

  // Every format's 32-bit value already carries instr[31] in bit 31,
  // so widening to XLEN is a plain signed extension.
  always_comb begin
    imm32 = '0;
    case (dec_fmt)
      FMT_I:   imm32 = {{20{s}}, in_instr[31:20]};
      FMT_S:   imm32 = {{20{s}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32 = {{20{s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm32 = {in_instr[31:12], 12'b0};
      FMT_J:   imm32 = {{12{s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    if (dec_zero) imm32 = '0;
  end

  always_comb begin
    dec.imm     = XLEN'($signed(imm32));
    dec.instr   = in_instr;
    dec.fmt     = dec_fmt;
    dec.illegal = dec_illegal;
    dec.tag     = in_tag;
  end

  // Handshake: a word moves on an edge where valid and ready are both high;
  // the producer holds valid and data stable until that edge.
  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready;
  assign drain    = out_v & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (!out_v || out_ready) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (accept) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (accept) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign out_valid   = out_v;
  assign out_imm     = out_q.imm;
  assign out_instr   = out_q.instr;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit explicit-format instance (A) and a 64-bit
// opcode-decoding instance (B), checked against an arithmetic reference model.
module tb_imm_gen_pipe;

  localparam int W = 108;  // {imm64, instr32, fmt3, illegal1, tag8}

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr, a_out_imm, a_out_instr;
  logic [2:0]  a_in_imm_src, a_out_fmt;
  logic [7:0]  a_in_tag, a_out_tag;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr, b_out_instr;
  logic [63:0] b_out_imm;
  logic [2:0]  b_in_imm_src, b_out_fmt;
  logic [7:0]  b_in_tag, b_out_tag;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int total = 0;
  int bad   = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .AUTO_DECODE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
    .in_imm_src(a_in_imm_src), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_instr(a_out_instr), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
    .out_tag(a_out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .AUTO_DECODE(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .in_imm_src(b_in_imm_src), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_instr(b_out_instr), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
    .out_tag(b_out_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] model_imm(input logic [31:0] w, input int f, input int xlen);
    longint v;
    logic [63:0] r;
    case (f)
      0: begin v = longint'(w >> 20); if (v >= 2048) v -= 4096; end
      1: begin
        v = longint'(((w >> 25) << 5) | ((w >> 7) & 32'h1F));
        if (v >= 2048) v -= 4096;
      end
      2: begin
        v = longint'((((w >> 31) & 32'd1) << 12) | (((w >> 7) & 32'd1) << 11) |
                     (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1));
        if (v >= 4096) v -= 8192;
      end
      3: begin
        v = longint'(w & 32'hFFFFF000);
        if (v >= 64'sd2147483648) v -= 64'sd4294967296;
      end
      4: begin
        v = longint'((((w >> 31) & 32'd1) << 20) | (((w >> 12) & 32'hFF) << 12) |
                     (((w >> 20) & 32'd1) << 11) | (((w >> 21) & 32'h3FF) << 1));
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    r = v;
    if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  function automatic void auto_map(input logic [6:0] op, output int f, output bit ill, output bit zero);
    f = 0; ill = 1'b0; zero = 1'b0;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: f = 0;
      7'b0100011: f = 1;
      7'b1100011: f = 2;
      7'b0110111, 7'b0010111: f = 3;
      7'b1101111: f = 4;
      7'b0110011: zero = 1'b1;
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [W-1:0] pack(input logic [63:0] imm, input logic [31:0] instr,
                                        input logic [2:0] fmt, input logic ill, input logic [7:0] tag);
    return {imm, instr, fmt, ill, tag};
  endfunction

  function automatic logic [W-1:0] exp_entry_a(input logic [31:0] w, input logic [2:0] src, input logic [7:0] tag);
    bit ill;
    ill = (src > 3'd4);
    return pack(ill ? 64'd0 : model_imm(w, int'(src), 32), w, src, ill, tag);
  endfunction

  // The format code reported for an illegal opcode is left open, so it is masked out.
  function automatic logic [W-1:0] exp_entry_b(input logic [31:0] w, input logic [7:0] tag);
    int f; bit ill; bit zero;
    auto_map(w[6:0], f, ill, zero);
    return pack((ill || zero) ? 64'd0 : model_imm(w, f, 64), w, ill ? 3'd0 : 3'(f), ill, tag);
  endfunction

  function automatic logic [W-1:0] view(input logic [W-1:0] e, input logic ill);
    logic [W-1:0] r;
    r = e;
    if (ill) r[11:9] = 3'd0;
    return r;
  endfunction

  function automatic logic [W-1:0] act_a();
    return pack({32'd0, a_out_imm}, a_out_instr, a_out_fmt, a_out_illegal, a_out_tag);
  endfunction

  function automatic logic [W-1:0] act_b();
    return pack(b_out_imm, b_out_instr, b_out_fmt, b_out_illegal, b_out_tag);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_a(input bit v, input logic [31:0] w, input logic [2:0] src,
                         input logic [7:0] tag, input bit ordy, output bit acc, output bit drn);
    a_in_valid = v; a_in_instr = w; a_in_imm_src = src; a_in_tag = tag; a_out_ready = ordy;
    acc = v && a_in_ready;
    drn = a_out_valid && ordy;
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input bit v, input logic [31:0] w, input logic [7:0] tag,
                         input bit ordy, output bit acc, output bit drn);
    b_in_valid = v; b_in_instr = w; b_in_tag = tag; b_out_ready = ordy;
    acc = v && b_in_ready;
    drn = b_out_valid && ordy;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_instr = 0; a_in_imm_src = 0; a_in_tag = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_instr = 0; b_in_imm_src = 0; b_in_tag = 0; b_out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    total++; if (act_a() !== '0) begin bad++; $display("FAIL reset_out_fields: got %h want 0", act_a()); end
    total++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || act_b() !== '0) begin
      bad++; $display("FAIL reset_b: got v=%b r=%b %h want v=0 r=1 0", b_out_valid, b_in_ready, act_b());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    logic [31:0] vec[5] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7, 32'hFFDFF06F};
    logic [31:0] res[5] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'hFFFFFFFC};
    bit acc, drn;
    for (int k = 0; k < 5; k++) begin
      drive_a(1'b1, vec[k], 3'(k), 8'(k), 1'b1, acc, drn);
      total++; if (!acc || a_in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d: got acc=%b in_ready=%b want 1 1", k, acc, a_in_ready); end
      total++; if (a_out_valid !== 1'b1 || a_out_imm !== res[k]) begin
        bad++; $display("FAIL stream_imm%0d: got v=%b %h want v=1 %h", k, a_out_valid, a_out_imm, res[k]);
      end
      total++; if (a_out_tag !== 8'(k) || a_out_fmt !== 3'(k) || a_out_instr !== vec[k] || a_out_illegal !== 1'b0) begin
        bad++; $display("FAIL stream_side%0d: got tag=%h fmt=%0d instr=%h ill=%b want tag=%h fmt=%0d instr=%h ill=0",
                        k, a_out_tag, a_out_fmt, a_out_instr, a_out_illegal, 8'(k), k, vec[k]);
      end
    end
    drive_a(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, acc, drn);
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL stream_empty: got %b want 0", a_out_valid); end
  endtask

  task automatic test_auto_decode();
    logic [31:0] vec[4] = '{32'hFFDFF06F, 32'h800000B7, 32'h00000000, 32'h002081B3};
    logic [63:0] imm[4] = '{64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000, 64'd0, 64'd0};
    bit acc, drn;
    for (int k = 0; k < 4; k++) begin
      drive_b(1'b1, vec[k], 8'h40 + 8'(k), 1'b1, acc, drn);
      total++; if (b_out_valid !== 1'b1 || b_out_imm !== imm[k] || b_out_tag !== 8'h40 + 8'(k)) begin
        bad++; $display("FAIL auto_imm%0d: got v=%b %h tag=%h want v=1 %h tag=%h", k, b_out_valid, b_out_imm, b_out_tag, imm[k], 8'h40 + 8'(k));
      end
      total++;
      case (k)
        0: if (b_out_fmt !== 3'd4 || b_out_illegal !== 1'b0) begin bad++; $display("FAIL auto_fmt_j: got fmt=%0d ill=%b want 4 0", b_out_fmt, b_out_illegal); end
        1: if (b_out_fmt !== 3'd3 || b_out_illegal !== 1'b0) begin bad++; $display("FAIL auto_fmt_u: got fmt=%0d ill=%b want 3 0", b_out_fmt, b_out_illegal); end
        2: if (b_out_illegal !== 1'b1) begin bad++; $display("FAIL auto_illegal: got ill=%b want 1", b_out_illegal); end
        default: if (b_out_fmt !== 3'd0 || b_out_illegal !== 1'b0) begin bad++; $display("FAIL auto_rtype: got fmt=%0d ill=%b want 0 0", b_out_fmt, b_out_illegal); end
      endcase
    end
    drive_b(1'b0, 32'd0, 8'd0, 1'b1, acc, drn);
  endtask

  task automatic test_illegal();
    bit acc, drn;
    drive_a(1'b1, 32'hFFF00093, 3'b111, 8'h09, 1'b1, acc, drn);
    total++; if (a_out_valid !== 1'b1 || a_out_illegal !== 1'b1 || a_out_imm !== 32'd0) begin
      bad++; $display("FAIL illegal_src7: got v=%b ill=%b imm=%h want 1 1 0", a_out_valid, a_out_illegal, a_out_imm);
    end
    total++; if (a_out_fmt !== 3'b111 || a_out_tag !== 8'h09 || a_out_instr !== 32'hFFF00093) begin
      bad++; $display("FAIL illegal_side: got fmt=%0d tag=%h instr=%h want 7 09 fff00093", a_out_fmt, a_out_tag, a_out_instr);
    end
    drive_a(1'b1, 32'h80000037, 3'b101, 8'h0A, 1'b1, acc, drn);
    total++; if (a_out_illegal !== 1'b1 || a_out_imm !== 32'd0 || a_out_fmt !== 3'b101) begin
      bad++; $display("FAIL illegal_src5: got ill=%b imm=%h fmt=%0d want 1 0 5", a_out_illegal, a_out_imm, a_out_fmt);
    end
    drive_a(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, acc, drn);
  endtask

  task automatic test_backpressure();
    logic [31:0] w[4] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123450B7};
    logic [W-1:0] e;
    int idx = 0;
    int got = 0;
    bit acc, drn, ordy;
    exp_a.delete();
    for (int cyc = 0; cyc < 14; cyc++) begin
      ordy = (cyc == 0) || (cyc >= 6);
      if (a_out_valid && ordy) begin
        total++;
        if (exp_a.size() == 0) begin bad++; $display("FAIL bp_extra: got %h want none", act_a()); end
        else begin
          e = exp_a.pop_front();
          if (act_a() !== e) begin bad++; $display("FAIL bp_order%0d: got %h want %h", got, act_a(), e); end
        end
        got++;
      end
      drive_a(idx < 4, (idx < 4) ? w[idx] : 32'd0, 3'(idx), 8'h10 + 8'(idx), ordy, acc, drn);
      if (acc) begin exp_a.push_back(exp_entry_a(w[idx], 3'(idx), 8'h10 + 8'(idx))); idx++; end
      if (cyc >= 1 && cyc <= 5) begin
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_c%0d: got %b want 0", cyc, a_in_ready); end
        total++; if (a_out_valid !== 1'b1 || act_a() !== exp_entry_a(w[0], 3'd0, 8'h10)) begin
          bad++; $display("FAIL bp_hold_c%0d: got v=%b %h want v=1 %h", cyc, a_out_valid, act_a(), exp_entry_a(w[0], 3'd0, 8'h10));
        end
      end
      if (cyc == 5) begin
        total++; if (idx !== 2) begin bad++; $display("FAIL bp_absorbed: got %0d want 2", idx); end
      end
    end
    total++; if (got !== 4 || idx !== 4 || exp_a.size() !== 0) begin
      bad++; $display("FAIL bp_delivered: got out=%0d in=%0d left=%0d want 4 4 0", got, idx, exp_a.size());
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit acc, drn;
    drive_a(1'b1, 32'h00500093, 3'd0, 8'h21, 1'b0, acc, drn);
    drive_a(1'b1, 32'h00600093, 3'd0, 8'h22, 1'b0, acc, drn);
    a_in_valid = 1'b0;
    total++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      bad++; $display("FAIL rmid_full: got in_ready=%b out_valid=%b want 0 1", a_in_ready, a_out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_async: got out_valid=%b in_ready=%b want 0 1", a_out_valid, a_in_ready);
    end
    total++; if (act_a() !== '0) begin bad++; $display("FAIL rmid_clear: got %h want 0", act_a()); end
    exp_a.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_a(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, acc, drn);
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rmid_remnant: got %b want 0", a_out_valid); end
    drive_a(1'b1, 32'h00700093, 3'd0, 8'h77, 1'b1, acc, drn);
    total++; if (a_out_valid !== 1'b1 || a_out_tag !== 8'h77 || a_out_imm !== 32'd7) begin
      bad++; $display("FAIL rmid_next: got v=%b tag=%h imm=%h want 1 77 7", a_out_valid, a_out_tag, a_out_imm);
    end
    drive_a(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, acc, drn);
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rmid_single: got %b want 0", a_out_valid); end
  endtask

  task automatic test_random_a(input int n);
    logic [W-1:0] e, prev;
    logic [31:0] pw;
    logic [2:0] ps;
    logic [7:0] pt;
    bit pv = 0, stalled = 0, acc, drn, ordy;
    int sent = 0, got = 0, cyc = 0;
    exp_a.delete();
    pw = 0; ps = 0; pt = 0; prev = '0;
    while (got < n && cyc < 60000) begin
      ordy = ($urandom_range(0, 9) < 7);
      if (!pv && sent < n && $urandom_range(0, 9) < 7) begin
        pv = 1'b1;
        pw = $urandom;
        ps = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        pt = 8'(sent);
      end
      if (stalled) begin
        total++; if (a_out_valid !== 1'b1 || act_a() !== prev) begin
          bad++; $display("FAIL rand_a_stable: got v=%b %h want v=1 %h", a_out_valid, act_a(), prev);
        end
      end
      if (a_out_valid && ordy) begin
        total++;
        if (exp_a.size() == 0) begin bad++; $display("FAIL rand_a_extra: got %h want none", act_a()); end
        else begin
          e = exp_a.pop_front();
          if (act_a() !== e) begin bad++; $display("FAIL rand_a_data%0d: got %h want %h", got, act_a(), e); end
        end
        got++;
      end
      stalled = a_out_valid && !ordy;
      prev = act_a();
      drive_a(pv, pw, ps, pt, ordy, acc, drn);
      if (acc) begin exp_a.push_back(exp_entry_a(pw, ps, pt)); sent++; pv = 1'b0; end
      cyc++;
    end
    total++; if (got !== n || exp_a.size() !== 0) begin
      bad++; $display("FAIL rand_a_count: got %0d left=%0d want %0d left=0", got, exp_a.size(), n);
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_random_b(input int n);
    logic [6:0] ops[12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0000000, 7'b1111111};
    logic [W-1:0] e;
    logic [31:0] pw, r;
    logic [7:0] pt;
    bit pv = 0, acc, drn, ordy;
    int sent = 0, got = 0, cyc = 0;
    exp_b.delete();
    pw = 0; pt = 0;
    while (got < n && cyc < 20000) begin
      ordy = ($urandom_range(0, 9) < 6);
      if (!pv && sent < n && $urandom_range(0, 9) < 8) begin
        pv = 1'b1;
        r = $urandom;
        pw = {r[31:7], (($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)])};
        pt = 8'(sent);
      end
      if (b_out_valid && ordy) begin
        total++;
        if (exp_b.size() == 0) begin bad++; $display("FAIL rand_b_extra: got %h want none", act_b()); end
        else begin
          e = exp_b.pop_front();
          if (view(act_b(), e[8]) !== view(e, e[8])) begin
            bad++; $display("FAIL rand_b_data%0d: got %h want %h", got, act_b(), e);
          end
        end
        got++;
      end
      drive_b(pv, pw, pt, ordy, acc, drn);
      if (acc) begin exp_b.push_back(exp_entry_b(pw, pt)); sent++; pv = 1'b0; end
      cyc++;
    end
    total++; if (got !== n || exp_b.size() !== 0) begin
      bad++; $display("FAIL rand_b_count: got %0d left=%0d want %0d left=0", got, exp_b.size(), n);
    end
    b_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_auto_decode();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random_a(10000);
    test_random_b(2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
